// File: rtl/gen_raddr.sv
// gen_raddr: read-address generator for the three-bank sr line buffer.
// Ports: SYS_CLK/SYS_NRST clock and async active-low reset; data_sop_i frame start;
// wbank_update_i one row written; rraddr_start_i row base address; pic_size_i/padding_i
// frame format; rready_i consumer accept; rd_vld_o/raddr_o/rbank_sel_o read port;
// pad_top_o/pad_bot_o zero-row flags; row_done_o/frame_done_o pulses; wready_o writer backpressure.
module gen_raddr #(
  parameter int AW = 10
) (
  input  logic          SYS_CLK,
  input  logic          SYS_NRST,
  input  logic          data_sop_i,
  input  logic          wbank_update_i,
  input  logic [AW-1:0] rraddr_start_i,
  input  logic [5:0]    pic_size_i,
  input  logic          padding_i,
  input  logic          rready_i,
  output logic          rd_vld_o,
  output logic [AW-1:0] raddr_o,
  output logic [1:0]    rbank_sel_o,
  output logic          pad_top_o,
  output logic          pad_bot_o,
  output logic          row_done_o,
  output logic          frame_done_o,
  output logic          wready_o
);
  typedef enum logic [1:0] {IDLE, WAIT, READ, ADV} state_t;
  state_t        state_q, state_d;
  logic [1:0]    avail_q, avail_d, bank_q, bank_d;
  logic [8:0]    row_q, row_d, nm1_q, nm1_d, h;
  logic [AW-1:0] addr_q, addr_d, start_q, start_d, last_q, last_d;
  logic          pad_q, pad_d, sop, upd, consume, last_row, need_ok;
  logic          vld_q, ptop_q, pbot_q, rdone_q, fdone_q, wrdy_q;
  logic          vld_d, ptop_d, pbot_d, rdone_d, fdone_d, wrdy_d;
  assign h        = {pic_size_i, 3'b000};
  assign sop      = data_sop_i && pic_size_i != 6'd0;
  assign last_row = row_q == nm1_q;
  assign need_ok  = avail_q >= ((pad_q && (row_q == 9'd0 || last_row)) ? 2'd2 : 2'd3);
  // rows arriving while idle belong to no frame; the next sop clears them anyway
  assign upd      = wbank_update_i && state_q != IDLE;
  // the padded first row reuses the top bank for the next row, so it frees nothing
  assign consume  = state_q == ADV && !(pad_q && row_q == 9'd0);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    bank_d  = bank_q;
    pad_d   = pad_q;
    start_d = start_q;
    last_d  = last_q;
    nm1_d   = nm1_q;
    avail_d = (upd && !consume) ? avail_q + {1'b0, avail_q != 2'd3} :
              (!upd && consume) ? avail_q - 2'd1 : avail_q;
    if (state_q == WAIT && need_ok) begin
      state_d = READ;
      addr_d  = start_q;
    end
    if (state_q == READ && rready_i) begin
      addr_d  = addr_q + AW'(1);
      state_d = addr_q == last_q ? ADV : READ;
    end
    if (state_q == ADV) begin
      row_d   = last_row ? 9'd0 : row_q + 9'd1;
      bank_d  = last_row ? 2'd0 : consume ? (bank_q == 2'd2 ? 2'd0 : bank_q + 2'd1) : bank_q;
      avail_d = last_row ? 2'd0 : avail_d;
      state_d = last_row ? IDLE : WAIT;
    end
    if (sop) begin
      state_d = WAIT;
      avail_d = 2'd0;
      bank_d  = 2'd0;
      row_d   = 9'd0;
      pad_d   = padding_i;
      start_d = rraddr_start_i;
      last_d  = rraddr_start_i + AW'(h) - AW'(1);
      nm1_d   = padding_i ? h - 9'd1 : h - 9'd3;
    end
  end
  assign vld_d   = state_d == READ;
  assign ptop_d  = pad_d && row_d == 9'd0 && vld_d;
  assign pbot_d  = pad_d && row_d == nm1_d && vld_d;
  assign rdone_d = state_d == ADV;
  assign fdone_d = state_d == ADV && row_d == nm1_d;
  assign wrdy_d  = avail_d != 2'd3;
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q <= IDLE;
      avail_q <= 2'd0;
      bank_q  <= 2'd0;
      row_q   <= 9'd0;
      nm1_q   <= 9'd0;
      addr_q  <= '0;
      start_q <= '0;
      last_q  <= '0;
      pad_q   <= 1'b0;
      vld_q   <= 1'b0;
      ptop_q  <= 1'b0;
      pbot_q  <= 1'b0;
      rdone_q <= 1'b0;
      fdone_q <= 1'b0;
      wrdy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      avail_q <= avail_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      nm1_q   <= nm1_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      vld_q   <= vld_d;
      ptop_q  <= ptop_d;
      pbot_q  <= pbot_d;
      rdone_q <= rdone_d;
      fdone_q <= fdone_d;
      wrdy_q  <= wrdy_d;
    end
  end
  assign rd_vld_o     = vld_q;
  assign raddr_o      = addr_q;
  assign rbank_sel_o  = bank_q;
  assign pad_top_o    = ptop_q;
  assign pad_bot_o    = pbot_q;
  assign row_done_o   = rdone_q;
  assign frame_done_o = fdone_q;
  assign wready_o     = wrdy_q;
endmodule

// File: tb/tb_gen_raddr.sv
// tb_gen_raddr: directed bench for gen_raddr.
module tb_gen_raddr;
  logic       SYS_CLK = 1'b0;
  logic       SYS_NRST;
  logic       data_sop_i, wbank_update_i, padding_i, rready_i;
  logic [9:0] rraddr_start_i, raddr_o;
  logic [5:0] pic_size_i;
  logic       rd_vld_o, pad_top_o, pad_bot_o, row_done_o, frame_done_o, wready_o;
  logic [1:0] rbank_sel_o;
  logic       auto_wr = 1'b0, man_upd = 1'b0;
  int         wcnt = 0, wlimit = 0;
  int         n_chk = 0, n_fail = 0;
  gen_raddr #(.AW(10)) dut (
    .SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST), .data_sop_i(data_sop_i),
    .wbank_update_i(wbank_update_i), .rraddr_start_i(rraddr_start_i),
    .pic_size_i(pic_size_i), .padding_i(padding_i), .rready_i(rready_i),
    .rd_vld_o(rd_vld_o), .raddr_o(raddr_o), .rbank_sel_o(rbank_sel_o),
    .pad_top_o(pad_top_o), .pad_bot_o(pad_bot_o), .row_done_o(row_done_o),
    .frame_done_o(frame_done_o), .wready_o(wready_o)
  );
  always #5 SYS_CLK = ~SYS_CLK;
  // writer: either follows wready_o up to wlimit rows, or replays man_upd
  initial begin
    wbank_update_i = 1'b0;
    forever begin
      @(posedge SYS_CLK);
      #2;
      if (auto_wr) begin
        wbank_update_i = wcnt < wlimit && wready_o;
        if (wbank_update_i) wcnt++;
      end else wbank_update_i = man_upd;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  typedef struct {
    logic [5:0]  ps;
    logic        pad;
    logic [9:0]  start;
    logic        tog;
    int          rows;
    logic [31:0] banks;
  } vec_t;
  vec_t tv [4];
  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic sop(input logic [5:0] ps, input logic pad, input logic [9:0] start);
    data_sop_i = 1'b1;
    pic_size_i = ps;
    padding_i = pad;
    rraddr_start_i = start;
    tick();
    data_sop_i = 1'b0;
  endtask
  task automatic upd();
    man_upd = 1'b1;
    tick();
    man_upd = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!row_done_o && n < 40) begin
      tick();
      n++;
    end
    chk(name, row_done_o, 1);
  endtask
  task automatic run_frame(input vec_t v);
    int w = 8 * int'(v.ps);
    int beat = 0, row = 0, budget = 0;
    logic [9:0] ea;
    rready_i = 1'b1;
    sop(v.ps, v.pad, v.start);
    wlimit = wcnt + w;
    auto_wr = 1'b1;
    while (row < v.rows && budget < 3000) begin
      tick();
      budget++;
      if (rd_vld_o) begin
        ea = v.start + 10'(beat);
        chk("raddr", raddr_o, ea);
        chk("rbank_sel", rbank_sel_o, v.banks[2*row +: 2]);
        chk("pad_top", pad_top_o, v.pad && row == 0);
        chk("pad_bot", pad_bot_o, v.pad && row == v.rows - 1);
        rready_i = v.tog ? ~rready_i : 1'b1;
        if (rready_i) beat++;
      end
      if (row_done_o) begin
        chk("row_len", beat, w);
        chk("frame_done", frame_done_o, row == v.rows - 1);
        chk("vld_gap", rd_vld_o, 0);
        row++;
        beat = 0;
      end
    end
    chk("row_count", row, v.rows);
    tick();
    chk("idle_after_frame", {rd_vld_o, row_done_o, frame_done_o}, 0);
    chk("rows_written", wcnt, wlimit);
    auto_wr = 1'b0;
  endtask
  initial begin
    bit seen;
    SYS_NRST = 1'b0;
    data_sop_i = 1'b0;
    padding_i = 1'b0;
    pic_size_i = 6'd0;
    rraddr_start_i = 10'd0;
    rready_i = 1'b0;
    tv[0] = '{6'd1, 1'b0, 10'd0, 1'b0, 6, 32'h0000_0924};
    tv[1] = '{6'd1, 1'b1, 10'd16, 1'b0, 8, 32'h0000_2490};
    tv[2] = '{6'd1, 1'b0, 10'd0, 1'b1, 6, 32'h0000_0924};
    tv[3] = '{6'd2, 1'b1, 10'd1020, 1'b0, 16, 32'h9249_2490};
    repeat (3) @(negedge SYS_CLK);
    SYS_NRST = 1'b1;
    tick();
    chk("reset_outputs", {rd_vld_o, raddr_o, rbank_sel_o, pad_top_o, pad_bot_o, row_done_o, frame_done_o, wready_o}, 32'h1);
    sop(6'd0, 1'b1, 10'd0);
    repeat (3) upd();
    repeat (2) tick();
    chk("bad_sop_vld", rd_vld_o, 0);
    chk("bad_sop_wready", wready_o, 1);
    for (int i = 0; i < 4; i++) run_frame(tv[i]);
    rready_i = 1'b0;
    sop(6'd1, 1'b0, 10'd0);
    upd();
    chk("wready_after_1", wready_o, 1);
    upd();
    chk("wready_after_2", wready_o, 1);
    upd();
    chk("wready_after_3", wready_o, 0);
    upd();
    chk("full_vld", rd_vld_o, 1);
    chk("full_raddr", raddr_o, 0);
    chk("full_wready", wready_o, 0);
    rready_i = 1'b1;
    wait_done("row_a_done");
    chk("wready_in_adv", wready_o, 0);
    tick();
    chk("wready_after_adv", wready_o, 1);
    repeat (3) tick();
    chk("dropped_4th_update", rd_vld_o, 0);
    upd();
    tick();
    chk("row_b_vld", rd_vld_o, 1);
    chk("row_b_bank", rbank_sel_o, 1);
    wait_done("row_b_done");
    upd();
    chk("upd_with_adv_wready", wready_o, 0);
    chk("upd_with_adv_vld", rd_vld_o, 0);
    tick();
    chk("row_c_vld", rd_vld_o, 1);
    chk("row_c_bank", rbank_sel_o, 2);
    repeat (2) tick();
    man_upd = 1'b1;
    sop(6'd2, 1'b0, 10'd100);
    man_upd = 1'b0;
    chk("sop_mid_vld", rd_vld_o, 0);
    chk("sop_mid_row_done", row_done_o, 0);
    chk("sop_mid_wready", wready_o, 1);
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen |= row_done_o | rd_vld_o;
    end
    chk("sop_mid_quiet", seen, 0);
    upd();
    upd();
    repeat (3) tick();
    chk("sop_cleared_avail", rd_vld_o, 0);
    upd();
    tick();
    chk("sop_new_vld", rd_vld_o, 1);
    chk("sop_new_raddr", raddr_o, 100);
    chk("sop_new_bank", rbank_sel_o, 0);
    repeat (3) tick();
    #2;
    SYS_NRST = 1'b0;
    #1;
    chk("async_reset", {rd_vld_o, raddr_o, rbank_sel_o, pad_top_o, pad_bot_o, row_done_o, frame_done_o, wready_o}, 32'h1);
    @(negedge SYS_CLK);
    SYS_NRST = 1'b1;
    tick();
    repeat (3) upd();
    repeat (2) tick();
    chk("idle_after_reset_vld", rd_vld_o, 0);
    chk("idle_after_reset_wready", wready_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
